qlf_dsp_mode_cfg_loader: RTL

//  Serial receiver and decoder for QL_DSP2 MODE_BITS configuration frames.
//  - Deserialises a 93-bit frame, validates it and stages it in a shadow register.
//  - On commit_i, applies the staged frame atomically to the active mode outputs,

---
 rtl/qlf_k6n10f_dsp_cfg_pkg.sv | 48 ++++
 rtl/qlf_dsp_cfg_shifter.sv | 50 +++++
 rtl/qlf_dsp_mode_cfg_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/qlf_k6n10f_dsp_cfg_pkg.sv
// ============================================================================
// Module   : qlf_k6n10f_dsp_cfg_pkg
// Purpose  : Shared widths, MODE_BITS field offsets and loader state encoding.
//            Build option: QL_DSP_CFG_PARITY_EN appends an even-parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package qlf_k6n10f_dsp_cfg_pkg;

    localparam int MODE_W     = 93;
    localparam int COEFF_W    = 20;
    localparam int NUM_COEFF  = 4;
    localparam int CNT_W      = 7;
`ifdef QL_DSP_CFG_PARITY_EN
    localparam int FRAME_LEN  = MODE_W + 1;
`else
    localparam int FRAME_LEN  = MODE_W;
`endif

    localparam int COEFF0_LSB    = 0;
    localparam int FRACTURED_BIT = 80;
    localparam int OSEL_LSB      = 81;
    localparam int SAT_BIT       = 84;
    localparam int SHR_LSB       = 85;
    localparam int ROUND_BIT     = 91;
    localparam int REGIN_BIT     = 92;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        PENDING = 2'd3
    } state_e;

    // A fractured tile only uses the low half of each coefficient.
    function automatic logic fields_invalid(input logic [MODE_W-1:0] m);
        logic hi_set;
        hi_set = 1'b0;
        for (int n = 0; n < NUM_COEFF; n++) begin
            hi_set = hi_set | (|m[COEFF0_LSB + n*COEFF_W + COEFF_W/2 +: COEFF_W/2]);
        end
        return m[FRACTURED_BIT] & hi_set;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qlf_dsp_cfg_shifter.sv
// ============================================================================
// Module   : qlf_dsp_cfg_shifter
// Purpose  : Shadow shift register (LSB-in) with bit counter and last-bit flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qlf_dsp_cfg_shifter
    import qlf_k6n10f_dsp_cfg_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 shift_i,
    input  logic                 bit_i,
    output logic [FRAME_LEN-1:0] shadow_o,
    output logic                 last_o
);

    logic [FRAME_LEN-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            shadow_d = '0;
            cnt_d    = '0;
        end else if (shift_i) begin
            shadow_d = {shadow_q[FRAME_LEN-2:0], bit_i};
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_o = shadow_q;
    assign last_o   = (cnt_q == CNT_W'(FRAME_LEN - 1));

endmodule

`default_nettype wire

// File: rtl/qlf_dsp_mode_cfg_loader.sv
// ============================================================================
// Module   : qlf_dsp_mode_cfg_loader
// Purpose  : Serial loader for QL_DSP2 MODE_BITS: shift, validate, stage, commit.
//            Build option: QL_DSP_CFG_PARITY_EN enables trailing even parity.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qlf_dsp_mode_cfg_loader
    import qlf_k6n10f_dsp_cfg_pkg::*;
(
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         cfg_start_i,
    input  logic                         cfg_bit_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic                         commit_i,
    output logic                         busy_o,
    output logic                         pending_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [MODE_W-1:0]            mode_bits_o,
    output logic                         fractured_o,
    output logic [2:0]                   output_select_o,
    output logic [5:0]                   shift_right_o,
    output logic                         saturate_enable_o,
    output logic                         round_o,
    output logic                         register_inputs_o,
    output logic [NUM_COEFF*COEFF_W-1:0] coeff_o
);

    state_e               state_q, state_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [MODE_W-1:0]    active_q, active_d;

    logic                 sh_clear;
    logic                 sh_shift;
    logic                 sh_last;
    logic [FRAME_LEN-1:0] shadow;
    logic [MODE_W-1:0]    data;
    logic                 parity_ok;

    qlf_dsp_cfg_shifter u_shifter (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .clear_i  (sh_clear),
        .shift_i  (sh_shift),
        .bit_i    (cfg_bit_i),
        .shadow_o (shadow),
        .last_o   (sh_last)
    );

`ifdef QL_DSP_CFG_PARITY_EN
    assign data      = shadow[FRAME_LEN-1:1];
    assign parity_ok = ~^shadow;
`else
    assign data      = shadow;
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        done_d   = 1'b0;
        active_d = active_q;
        sh_clear = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    state_d  = SHIFT;
                    err_d    = 1'b0;
                    sh_clear = 1'b1;
                end
            end
            SHIFT: begin
                // A restart wins over a bit presented in the same cycle.
                if (cfg_start_i) begin
                    sh_clear = 1'b1;
                end else if (cfg_valid_i) begin
                    sh_shift = 1'b1;
                    if (sh_last) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (fields_invalid(data) || !parity_ok) begin
                    err_d    = 1'b1;
                    sh_clear = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (commit_i) begin
                    active_d = data;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                if (cfg_start_i) begin
                    sh_clear = 1'b1;
                    state_d  = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign cfg_ready_o       = (state_q == SHIFT);
    assign busy_o            = (state_q != IDLE);
    assign pending_o         = (state_q == PENDING);
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign mode_bits_o       = active_q;
    assign fractured_o       = active_q[FRACTURED_BIT];
    assign output_select_o   = active_q[OSEL_LSB +: 3];
    assign shift_right_o     = active_q[SHR_LSB +: 6];
    assign saturate_enable_o = active_q[SAT_BIT];
    assign round_o           = active_q[ROUND_BIT];
    assign register_inputs_o = active_q[REGIN_BIT];
    assign coeff_o           = active_q[COEFF0_LSB +: NUM_COEFF*COEFF_W];

endmodule

`default_nettype wire
